alu_seq_core: RTL
=================

Name: alu_seq_core

Overview:
- Parametrised, handshaked successor to the 8-bit combinational ALU.
- Operand width is generic. Operands are accepted over a valid/ready interface.
- Single-cycle ops register their result; an iterative shift-add multiplier takes WIDTH cycles.
- A persistent carry flag supports add-with-carry chaining. Sits between the operand fetch stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- OP_W, 4, opcode width; fixed at 4 by the opcode map.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  core can accept a new operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  OP_W  opcode
- out_valid  out  1  result and flags valid
- out_ready  in  1  downstream accepts the result
- result  out  WIDTH  registered result
- carry  out  1  carry/borrow flag
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]
- ovf  out  1  signed overflow flag
- err  out  1  illegal opcode flag
- cflag  out  1  stored carry used by ADC

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): all outputs 0, state IDLE, cflag 0, multiplier aborted. Exception: in_ready reads 1 from the first cycle after reset.
- Opcode map:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A
  - 6 SHL A by 1, 7 SHR A by 1 (logical)
  - 8 MUL (low WIDTH bits), 9 ADC (A+B+cflag), 10 CMP (flags of A-B, result=A)
  - 11-15 illegal
- Handshake:
  - Transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output holds result, flags and out_valid stable until out_valid && out_ready. out_valid drops the cycle after consumption unless a new result is loaded on that same edge.
- States:
  - IDLE: on a non-MUL transfer, load the output register at the same edge; latency 1, one op per cycle sustainable. On a MUL transfer, go to BUSY with count=0.
  - BUSY: one shift-add step per cycle; in_ready=0. After step WIDTH-1, load the output register and return to IDLE. Result is valid at edge k+WIDTH+1 for acceptance at edge k.
- Width rules: all sums are computed at WIDTH+1 bits.
  - ADD/ADC: carry = bit WIDTH; ovf = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB/CMP: carry = borrow (A<B unsigned); ovf = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - AND/OR/XOR/NOT: carry=0, ovf=0.
  - SHL: carry=A[WIDTH-1], ovf=0. SHR: carry=A[0], ovf=0.
  - MUL: full 2*WIDTH product; carry = ovf = (upper half != 0).
- Flags: zero and neg are derived from result for every legal op. For CMP they derive from A-B while result=A.
- cflag:
  - Updated with carry on every legal completed op, at the same edge that out_valid is loaded.
  - ADC consumes the cflag value present at acceptance. Back-to-back ADCs see the prior ADC's carry because completion and next acceptance share an edge.
- Illegal op: result=0, err=1, carry=ovf=neg=0, zero=1, cflag unchanged, latency 1. err=0 for all legal ops.
- rst mid-BUSY: the multiply is discarded; no out_valid is produced.
- in_valid while in_ready=0: no transfer. Upstream must hold its inputs.

Decomposition:
- alu_pkg holds:
  - opcode localparams (OP_ADD..OP_CMP)
  - the state enum (IDLE, BUSY)
  - a flags struct (carry, zero, neg, ovf, err)
  - a function computing single-cycle result and flags
- One sub-module, alu_mul_iter:
  - Inputs: start, a, b; outputs: done pulse, 2*WIDTH product.
  - WIDTH-cycle shift-add with its own counter, cleared by rst.

Test Plan (WIDTH=8, out_ready=1 unless stated):
- ADD 10+5 accepted at edge k -> at k+1 result=15, out_valid=1, all flags 0; then SUB 5-10 -> result=251, carry=1, neg=1, ovf=0.
- ADD 127+1 -> result=128, ovf=1, neg=1, carry=0; ADD 200+100 -> result=44, carry=1, cflag=1; next ADC 1+1 -> result=3, cflag=0.
- MUL 20*13 at edge k -> in_ready=0 for 8 cycles; at k+9 result=4, carry=1, ovf=1. MUL 15*15 -> result=225, carry=0.
- Backpressure: out_ready=0 after ADD 10+5 -> result=15 and out_valid held, in_ready=0. Raise out_ready -> consumed, in_ready=1 the same cycle. CMP 5 vs 5 -> result=5, zero=1.
- Illegal op=12 with cflag=1 -> result=0, err=1, zero=1, cflag stays 1. SHL 0x81 -> result=0x02, carry=1; SHR 0x81 -> result=0x40, carry=1.
- rst asserted 3 cycles into MUL 20*13 -> next cycle all outputs 0, in_ready=1, no out_valid ever produced for that MUL.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types, opcode map and the single-cycle ALU evaluation for alu_seq_core.
// The evaluation function runs at MAX_W bits and masks down to the caller's width.
package alu_pkg;

  localparam int OP_W  = 4;
  localparam int MAX_W = 64;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL = 4'd8;
  localparam logic [OP_W-1:0] OP_ADC = 4'd9;
  localparam logic [OP_W-1:0] OP_CMP = 4'd10;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
    logic err;
  } flags_t;

  typedef logic [MAX_W-1:0] word_t;
  typedef logic [MAX_W:0]   wide_t;

  typedef struct packed {
    word_t  res;
    flags_t flags;
  } alu_res_t;

  // Operands must already be zero-extended from w bits; w must lie in 2..MAX_W.
  function automatic alu_res_t alu_compute(input logic [OP_W-1:0] op, input word_t a,
                                           input word_t b, input logic cin, input int w);
    alu_res_t o;
    wide_t    sum;
    wide_t    diff;
    word_t    mask;
    word_t    msb;
    word_t    r;
    logic     a_n;
    logic     b_n;
    logic     r_n;
    logic     c;
    logic     v;
    logic     illegal;
    mask    = {MAX_W{1'b1}} >> (MAX_W - w);
    msb     = word_t'(1) << (w - 1);
    sum     = wide_t'(a) + wide_t'(b) + wide_t'(cin && (op == OP_ADC));
    diff    = wide_t'(a) - wide_t'(b);
    a_n     = |(a & msb);
    b_n     = |(b & msb);
    r       = '0;
    c       = 1'b0;
    v       = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        r = sum[MAX_W-1:0] & mask;
        c = |(sum & (wide_t'(1) << w));
        v = (a_n == b_n) && ((|(r & msb)) != a_n);
      end
      OP_SUB, OP_CMP: begin
        r = diff[MAX_W-1:0] & mask;
        c = a < b;
        v = (a_n != b_n) && ((|(r & msb)) != a_n);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a & mask;
      OP_SHL: begin
        r = (a << 1) & mask;
        c = a_n;
      end
      OP_SHR: begin
        r = a >> 1;
        c = a[0];
      end
      default: illegal = 1'b1;
    endcase
    r_n           = |(r & msb);
    o.flags.carry = c;
    o.flags.ovf   = v;
    o.flags.zero  = (r == '0);
    o.flags.neg   = r_n;
    o.flags.err   = illegal;
    // CMP reports the flags of A-B but passes A through unchanged.
    o.res         = (op == OP_CMP) ? a : r;
    return o;
  endfunction

endpackage

// File: rtl/alu_seq_core_if.sv
// Operand/result handshake bundle between the fetch stage, the ALU core and writeback.
interface alu_seq_core_if #(parameter int WIDTH = 8);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             err;
  logic             cflag;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, zero, neg, ovf, err, cflag
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, zero, neg, ovf, err, cflag
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: WIDTH steps after start; done and product are
// combinational during the final step so the caller can register them on that edge.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign done    = busy && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU: single-cycle ops register in 1 cycle, MUL in WIDTH cycles.
// Input is refused while busy or while an unconsumed result is held.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W_P = OP_W
) (
  input logic           clk,
  input logic           rst,
  alu_seq_core_if.slave bus
);

  state_t             state;
  state_t             state_nxt;
  logic               xfer;
  logic               mul_start;
  logic               load_sc;
  logic               load_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   prod_lo;
  logic               prod_hi_nz;
  alu_res_t           sc;
  logic               unused_hi;

  logic               vld_q;
  logic [WIDTH-1:0]   res_q;
  flags_t             flg_q;
  logic               cflag_q;

  assign bus.in_ready = (state == IDLE) && (!vld_q || bus.out_ready);
  assign xfer         = bus.in_valid && bus.in_ready;

  always_comb begin
    sc = alu_compute(bus.op, word_t'(bus.a), word_t'(bus.b), cflag_q, WIDTH);
  end
  assign unused_hi = ^{sc.res, OP_W_P[0]};

  assign prod_lo    = prod[WIDTH-1:0];
  assign prod_hi_nz = |prod[2*WIDTH-1:WIDTH];

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    load_sc   = 1'b0;
    load_mul  = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (bus.op == OP_MUL) begin
            mul_start = 1'b1;
            state_nxt = BUSY;
          end else begin
            load_sc = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          load_mul  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cflag follows every legal completion so a following ADC sees it on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      cflag_q <= 1'b0;
    end else if (load_sc) begin
      vld_q <= 1'b1;
      res_q <= sc.res[WIDTH-1:0];
      flg_q <= sc.flags;
      if (!sc.flags.err) cflag_q <= sc.flags.carry;
    end else if (load_mul) begin
      vld_q       <= 1'b1;
      res_q       <= prod_lo;
      flg_q.carry <= prod_hi_nz;
      flg_q.zero  <= (prod_lo == '0);
      flg_q.neg   <= prod_lo[WIDTH-1];
      flg_q.ovf   <= prod_hi_nz;
      flg_q.err   <= 1'b0;
      cflag_q     <= prod_hi_nz;
    end else if (vld_q && bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.result    = res_q;
  assign bus.carry     = flg_q.carry;
  assign bus.zero      = flg_q.zero;
  assign bus.neg       = flg_q.neg;
  assign bus.ovf       = flg_q.ovf;
  assign bus.err       = flg_q.err;
  assign bus.cflag     = cflag_q;

endmodule
